// File: rtl/micro_decode_table_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : micro_decode_pkg
//  Description : Shared types and constants for the micro-command decode
//                table: micro-command field constants, the packed
//                micro-command and table-entry types, and the 12-entry
//                default table loaded at reset.
//  Revision    : 1.0 - initial release
// ============================================================================
package micro_decode_pkg;

    localparam int C_PATTERN_LEN = 15;
    localparam int C_MICRO_LEN   = 13;
    localparam int C_DEFAULT_NR  = 12;

    // Micro-command field constants, already placed at their bit positions
    // so that entries can be built by OR-ing them together.
    localparam logic [12:0] REGEN       = 13'h1000;
    localparam logic [12:0] PCJEN       = 13'h0800;
    localparam logic [12:0] PCREN       = 13'h0400;
    localparam logic [12:0] MWEN_NONE   = 13'h0000;
    localparam logic [12:0] MWEN_B      = 13'h0100;
    localparam logic [12:0] MWEN_H      = 13'h0200;
    localparam logic [12:0] MWEN_W      = 13'h0300;
    localparam logic [12:0] MREN_NONE   = 13'h0000;
    localparam logic [12:0] MREN_B      = 13'h0040;
    localparam logic [12:0] MREN_H      = 13'h0080;
    localparam logic [12:0] MREN_W      = 13'h00C0;
    localparam logic [12:0] ALUOP_ADD   = 13'h0000;
    localparam logic [12:0] IMM_TYPE_R  = 13'h0000;
    localparam logic [12:0] IMM_TYPE_I  = 13'h0001;
    localparam logic [12:0] IMM_TYPE_S  = 13'h0002;
    localparam logic [12:0] IMM_TYPE_SB = 13'h0003;
    localparam logic [12:0] IMM_TYPE_UJ = 13'h0005;
    localparam logic [12:0] IMM_TYPE_U  = 13'h0006;

    // Compare masks over {func7, func3, opcode[6:2]}
    localparam logic [14:0] MASK_OP   = 15'b0000000_000_11111;
    localparam logic [14:0] MASK_F3OP = 15'b0000000_111_11111;
    localparam logic [14:0] MASK_ALL  = 15'b1111111_111_11111;

    typedef struct packed {
        logic       regen;
        logic       pcjen;
        logic       pcren;
        logic [1:0] mwen;
        logic [1:0] mren;
        logic [2:0] aluop;
        logic [2:0] imm;
    } micro_t;

    typedef struct packed {
        logic                     en;
        logic [C_PATTERN_LEN-1:0] pattern;
        logic [C_PATTERN_LEN-1:0] mask;
        micro_t                   micro;
    } entry_t;

    localparam entry_t DEFAULT_TABLE [C_DEFAULT_NR] = '{
        '{1'b1, 15'b0000000_000_01101, MASK_OP,   REGEN | ALUOP_ADD | IMM_TYPE_U},          // LUI
        '{1'b1, 15'b0000000_000_00101, MASK_OP,   REGEN | PCREN | ALUOP_ADD | IMM_TYPE_U},  // AUIPC
        '{1'b1, 15'b0000000_000_11011, MASK_OP,   REGEN | PCJEN | IMM_TYPE_UJ},             // JAL
        '{1'b1, 15'b0000000_000_11001, MASK_F3OP, REGEN | PCJEN | IMM_TYPE_I},              // JALR
        '{1'b1, 15'b0000000_000_00000, MASK_F3OP, REGEN | MREN_B | IMM_TYPE_I},             // LB
        '{1'b1, 15'b0000000_001_00000, MASK_F3OP, REGEN | MREN_H | IMM_TYPE_I},             // LH
        '{1'b1, 15'b0000000_010_00000, MASK_F3OP, REGEN | MREN_W | IMM_TYPE_I},             // LW
        '{1'b1, 15'b0000000_000_01000, MASK_F3OP, MWEN_B | IMM_TYPE_S},                     // SB
        '{1'b1, 15'b0000000_001_01000, MASK_F3OP, MWEN_H | IMM_TYPE_S},                     // SH
        '{1'b1, 15'b0000000_010_01000, MASK_F3OP, MWEN_W | IMM_TYPE_S},                     // SW
        '{1'b1, 15'b0000000_000_00100, MASK_F3OP, REGEN | ALUOP_ADD | IMM_TYPE_I},          // ADDI
        '{1'b1, 15'b0000000_000_11100, MASK_ALL,  IMM_TYPE_R}                               // EBREAK
    };

    // Reset image of entry i: defaults for the low entries, disabled beyond.
    // Searching instead of indexing keeps the lookup in range for any i.
    function automatic entry_t reset_entry(input int i);
        entry_t e;
        e = '0;
        for (int k = 0; k < C_DEFAULT_NR; k++) begin
            if (k == i) begin
                e = DEFAULT_TABLE[k];
            end
        end
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/micro_decode_table_if.sv
`default_nettype none
// ============================================================================
//  Module      : micro_decode_table_if
//  Description : Valid/ready decode stream. The slave modport is the decode
//                stage (takes in_*, drives in_ready and out_*); the master
//                modport is fetch + execute around it.
//  Ports       : in_valid/in_ready/in_inst  - compressed instruction in
//                out_valid/out_ready/out_*  - decoded micro-command out
//  Revision    : 1.0 - initial release
// ============================================================================
interface micro_decode_table_if #(
    parameter int PATTERN_LEN = 15,
    parameter int MICRO_LEN   = 13,
    parameter int IDX_W       = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [PATTERN_LEN-1:0] in_inst;
    logic                   out_valid;
    logic                   out_ready;
    logic [MICRO_LEN-1:0]   out_micro;
    logic                   out_hit;
    logic [IDX_W-1:0]       out_idx;

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_micro, out_hit, out_idx
    );

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_micro, out_hit, out_idx
    );
endinterface
`default_nettype wire

// File: rtl/micro_decode_table_prio_match_enc.sv
`default_nettype none
// ============================================================================
//  Module      : prio_match_enc
//  Description : Priority encoder over the per-entry match vector. Reports
//                whether any entry matched and the lowest matching index
//                (0 when nothing matched).
//  Ports       : i_match [N]     - one bit per table entry
//                o_any           - at least one bit set
//                o_idx [IDX_W]   - lowest set bit position
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_match_enc #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  wire logic [N-1:0]     i_match,
    output logic                  o_any,
    output logic [IDX_W-1:0]      o_idx
);

    // Scan from the top down so the last assignment is the lowest index.
    always_comb begin
        o_any = |i_match;
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_match[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/micro_decode_table.sv
`default_nettype none
// ============================================================================
//  Module      : micro_decode_table
//  Description : Runtime-programmable instruction -> micro-command decode
//                table with a one-deep registered valid/ready output stage.
//                Each entry is {en, pattern, mask, micro}; lowest matching
//                index wins. Tracks a sticky illegal flag and a lookup count.
//  Ports       : clk, rst_n (async, active-low)
//                cfg_we/cfg_idx/cfg_en/cfg_pattern/cfg_mask/cfg_micro
//                                        - single-entry table write port
//                bus (slave)             - in_* / out_* decode stream
//                illegal_sticky, clr_illegal - miss flag and its clear
//                lookup_cnt              - accepted-input counter (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module micro_decode_table
    import micro_decode_pkg::*;
#(
    parameter int PATTERN_LEN = C_PATTERN_LEN,
    parameter int MICRO_LEN   = C_MICRO_LEN,
    parameter int ENTRY_NR    = 16,
    parameter int CNT_W       = 32,
    localparam int IDX_W      = $clog2(ENTRY_NR)
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   cfg_we,
    input  wire logic [IDX_W-1:0]       cfg_idx,
    input  wire logic                   cfg_en,
    input  wire logic [PATTERN_LEN-1:0] cfg_pattern,
    input  wire logic [PATTERN_LEN-1:0] cfg_mask,
    input  wire logic [MICRO_LEN-1:0]   cfg_micro,
    micro_decode_table_if.slave         bus,
    output logic                        illegal_sticky,
    input  wire logic                   clr_illegal,
    output logic [CNT_W-1:0]            lookup_cnt
);

    entry_t               r_table [ENTRY_NR];
    entry_t               w_cfg_entry;
    entry_t               w_sel;
    logic [ENTRY_NR-1:0]  w_match;
    logic                 w_any;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_xfer;

    logic                 r_out_valid;
    logic [MICRO_LEN-1:0] r_out_micro;
    logic                 r_out_hit;
    logic [IDX_W-1:0]     r_out_idx;
    logic                 r_illegal;
    logic [CNT_W-1:0]     r_cnt;

    // ------------------------------------------------------------------
    // Table storage. Lookups read r_table combinationally, so a write in
    // the same cycle as a transfer is only visible to later lookups.
    // ------------------------------------------------------------------
    assign w_cfg_entry = '{en:      cfg_en,
                           pattern: cfg_pattern,
                           mask:    cfg_mask,
                           micro:   micro_t'(cfg_micro)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRY_NR; i++) begin
                r_table[i] <= reset_entry(i);
            end
        end else if (cfg_we && (int'(cfg_idx) < ENTRY_NR)) begin
            r_table[cfg_idx] <= w_cfg_entry;
        end
    end

    // ------------------------------------------------------------------
    // Masked compare per entry, then lowest-index priority select.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < ENTRY_NR; gi++) begin : g_match
            assign w_match[gi] = r_table[gi].en &&
                ((bus.in_inst & r_table[gi].mask) == (r_table[gi].pattern & r_table[gi].mask));
        end
    endgenerate

    prio_match_enc #(
        .N     (ENTRY_NR),
        .IDX_W (IDX_W)
    ) u_prio (
        .i_match (w_match),
        .o_any   (w_any),
        .o_idx   (w_idx)
    );

    assign w_sel = r_table[w_idx];

    // ------------------------------------------------------------------
    // One-deep output register. A stalled result stays bit-stable until
    // the consumer takes it; a miss still produces a valid (zero) result
    // so the consumer can trap on out_hit=0.
    // ------------------------------------------------------------------
    assign bus.in_ready = !r_out_valid || bus.out_ready;
    assign w_xfer       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_micro <= '0;
            r_out_hit   <= 1'b0;
            r_out_idx   <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_hit   <= w_any;
            r_out_idx   <= w_idx;
            r_out_micro <= w_any ? MICRO_LEN'(w_sel.micro) : '0;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_micro = r_out_micro;
    assign bus.out_hit   = r_out_hit;
    assign bus.out_idx   = r_out_idx;

    // Accepted miss has priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (w_xfer && !w_any) begin
            r_illegal <= 1'b1;
        end else if (clr_illegal) begin
            r_illegal <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign illegal_sticky = r_illegal;
    assign lookup_cnt     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_micro_decode_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_micro_decode_table
//  Description : Directed self-checking bench for micro_decode_table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_decode_table;

    localparam int PATTERN_LEN = 15;
    localparam int MICRO_LEN   = 13;
    localparam int ENTRY_NR    = 16;
    localparam int CNT_W       = 32;
    localparam int IDX_W       = 4;

    localparam logic [14:0] INST_LUI   = 15'b0000000_000_01101;
    localparam logic [14:0] INST_ADDI  = 15'b1111111_000_00100;
    localparam logic [14:0] INST_BAD   = 15'b0000000_000_11111;
    localparam logic [14:0] INST_NEW   = 15'b0000000_000_01100;
    localparam logic [12:0] MICRO_LUI  = 13'b1_0_0_00_00_000_110;
    localparam logic [12:0] MICRO_ADDI = 13'b1_0_0_00_00_000_001;

    logic                   clk;
    logic                   rst_n;
    logic                   cfg_we;
    logic [IDX_W-1:0]       cfg_idx;
    logic                   cfg_en;
    logic [PATTERN_LEN-1:0] cfg_pattern;
    logic [PATTERN_LEN-1:0] cfg_mask;
    logic [MICRO_LEN-1:0]   cfg_micro;
    logic                   illegal_sticky;
    logic                   clr_illegal;
    logic [CNT_W-1:0]       lookup_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    micro_decode_table_if #(
        .PATTERN_LEN (PATTERN_LEN),
        .MICRO_LEN   (MICRO_LEN),
        .IDX_W       (IDX_W)
    ) bus ();

    micro_decode_table #(
        .PATTERN_LEN (PATTERN_LEN),
        .MICRO_LEN   (MICRO_LEN),
        .ENTRY_NR    (ENTRY_NR),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_en         (cfg_en),
        .cfg_pattern    (cfg_pattern),
        .cfg_mask       (cfg_mask),
        .cfg_micro      (cfg_micro),
        .bus            (bus),
        .illegal_sticky (illegal_sticky),
        .clr_illegal    (clr_illegal),
        .lookup_cnt     (lookup_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        cfg_we       = 1'b0;
        cfg_idx      = '0;
        cfg_en       = 1'b0;
        cfg_pattern  = '0;
        cfg_mask     = '0;
        cfg_micro    = '0;
        clr_illegal  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.out_ready = 1'b1;
        #12;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.out_hit !== 1'b0 || bus.out_idx !== 4'd0 || bus.out_micro !== 13'd0)
            $display("FAIL reset_out: valid=%b hit=%b idx=%0d micro=%h, want 0/0/0/0",
                     bus.out_valid, bus.out_hit, bus.out_idx, bus.out_micro);
        else pass_cnt++;
        total_cnt++;
        if (illegal_sticky !== 1'b0 || lookup_cnt !== 32'd0)
            $display("FAIL reset_state: illegal=%b cnt=%0d, want 0/0", illegal_sticky, lookup_cnt);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_lui();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_inst   = INST_LUI;
        tick();
        bus.in_valid  = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_micro !== MICRO_LUI || bus.out_hit !== 1'b1 || bus.out_idx !== 4'd0)
            $display("FAIL lui: valid=%b micro=%b hit=%b idx=%0d, want 1/%b/1/0",
                     bus.out_valid, bus.out_micro, bus.out_hit, bus.out_idx, MICRO_LUI);
        else pass_cnt++;
        total_cnt++;
        if (lookup_cnt !== 32'd1) $display("FAIL lui_cnt: got %0d want 1", lookup_cnt);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL lui_drain: out_valid=%b want 0", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = INST_LUI;
        tick();
        bus.in_inst   = INST_ADDI;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", bus.in_ready);
        else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            tick();
            total_cnt++;
            if (bus.out_valid !== 1'b1 || bus.out_micro !== MICRO_LUI || bus.out_idx !== 4'd0 || bus.out_hit !== 1'b1)
                $display("FAIL stall_hold[%0d]: valid=%b micro=%b idx=%0d hit=%b, want LUI held",
                         c, bus.out_valid, bus.out_micro, bus.out_idx, bus.out_hit);
            else pass_cnt++;
        end
        total_cnt++;
        if (lookup_cnt !== 32'd2) $display("FAIL stall_cnt: got %0d want 2", lookup_cnt);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", bus.in_ready);
        else pass_cnt++;
        tick();
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_micro !== MICRO_ADDI || bus.out_idx !== 4'd10 || bus.out_hit !== 1'b1)
            $display("FAIL addi: valid=%b micro=%b idx=%0d hit=%b, want 1/%b/10/1",
                     bus.out_valid, bus.out_micro, bus.out_idx, bus.out_hit, MICRO_ADDI);
        else pass_cnt++;
        total_cnt++;
        if (lookup_cnt !== 32'd3) $display("FAIL addi_cnt: got %0d want 3", lookup_cnt);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_illegal();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_inst   = INST_BAD;
        tick();
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_hit !== 1'b0 || bus.out_micro !== 13'd0 || bus.out_idx !== 4'd0)
            $display("FAIL miss_out: valid=%b hit=%b micro=%h idx=%0d, want 1/0/0/0",
                     bus.out_valid, bus.out_hit, bus.out_micro, bus.out_idx);
        else pass_cnt++;
        total_cnt++;
        if (illegal_sticky !== 1'b1) $display("FAIL miss_flag: got %b want 1", illegal_sticky);
        else pass_cnt++;
        clr_illegal = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        total_cnt++;
        if (illegal_sticky !== 1'b1) $display("FAIL clr_vs_miss: got %b want 1", illegal_sticky);
        else pass_cnt++;
        tick();
        clr_illegal = 1'b0;
        total_cnt++;
        if (illegal_sticky !== 1'b0) $display("FAIL clr_alone: got %b want 0", illegal_sticky);
        else pass_cnt++;
        total_cnt++;
        if (lookup_cnt !== 32'd5) $display("FAIL miss_cnt: got %0d want 5", lookup_cnt);
        else pass_cnt++;
    endtask

    task automatic test_cfg_write();
        cfg_we       = 1'b1;
        cfg_idx      = 4'd12;
        cfg_en       = 1'b1;
        cfg_pattern  = INST_NEW;
        cfg_mask     = 15'h7FFF;
        cfg_micro    = 13'h1000;
        bus.in_valid = 1'b1;
        bus.in_inst  = INST_NEW;
        tick();
        cfg_we = 1'b0;
        total_cnt++;
        if (bus.out_hit !== 1'b0 || bus.out_valid !== 1'b1)
            $display("FAIL cfg_same_cycle: hit=%b valid=%b, want 0/1", bus.out_hit, bus.out_valid);
        else pass_cnt++;
        tick();
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.out_hit !== 1'b1 || bus.out_idx !== 4'd12 || bus.out_micro !== 13'h1000)
            $display("FAIL cfg_next: hit=%b idx=%0d micro=%h, want 1/12/1000",
                     bus.out_hit, bus.out_idx, bus.out_micro);
        else pass_cnt++;
        clr_illegal = 1'b1;
        tick();
        clr_illegal = 1'b0;
    endtask

    task automatic test_priority();
        cfg_we      = 1'b1;
        cfg_idx     = 4'd13;
        cfg_en      = 1'b1;
        cfg_pattern = 15'b0000000_000_00100;
        cfg_mask    = 15'b0000000_111_11111;
        cfg_micro   = 13'h0ABC;
        tick();
        cfg_we       = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_inst  = INST_ADDI;
        tick();
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.out_idx !== 4'd10 || bus.out_micro !== MICRO_ADDI || bus.out_hit !== 1'b1)
            $display("FAIL prio_low: idx=%0d micro=%b hit=%b, want 10/%b/1",
                     bus.out_idx, bus.out_micro, bus.out_hit, MICRO_ADDI);
        else pass_cnt++;
        cfg_we  = 1'b1;
        cfg_idx = 4'd10;
        cfg_en  = 1'b0;
        tick();
        cfg_we       = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.out_idx !== 4'd13 || bus.out_micro !== 13'h0ABC || bus.out_hit !== 1'b1)
            $display("FAIL prio_disabled: idx=%0d micro=%h hit=%b, want 13/0abc/1",
                     bus.out_idx, bus.out_micro, bus.out_hit);
        else pass_cnt++;
        total_cnt++;
        if (lookup_cnt !== 32'd9) $display("FAIL prio_cnt: got %0d want 9", lookup_cnt);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = INST_LUI;
        tick();
        bus.in_valid  = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 1'b1 || lookup_cnt !== 32'd10)
            $display("FAIL pre_reset: valid=%b cnt=%0d, want 1/10", bus.out_valid, lookup_cnt);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || lookup_cnt !== 32'd0)
            $display("FAIL async_reset: valid=%b cnt=%0d, want 0/0", bus.out_valid, lookup_cnt);
        else pass_cnt++;
        tick();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_inst   = INST_NEW;
        tick();
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_hit !== 1'b0 || illegal_sticky !== 1'b1)
            $display("FAIL reset_entry12: valid=%b hit=%b illegal=%b, want 1/0/1",
                     bus.out_valid, bus.out_hit, illegal_sticky);
        else pass_cnt++;
        bus.in_inst = INST_ADDI;
        tick();
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.out_idx !== 4'd10 || bus.out_hit !== 1'b1 || lookup_cnt !== 32'd2)
            $display("FAIL reset_defaults: idx=%0d hit=%b cnt=%0d, want 10/1/2",
                     bus.out_idx, bus.out_hit, lookup_cnt);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_lui();
        test_back_to_back();
        test_illegal();
        test_cfg_write();
        test_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
